// File: rtl/dot_matrix_pkg.sv
// Shared definitions for the 8x8 dot-matrix scan driver: default geometry,
// scan state encoding and the polarity-aware row select helper.
package dot_matrix_pkg;

  localparam int DEF_ROWS         = 8;
  localparam int DEF_COLS         = 8;
  localparam int DEF_BLANK_CYCLES = 1;
  localparam int DEF_BLINK_FRAMES = 64;
  localparam int ROW_SEL_W        = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // One-hot select for row idx; callers truncate to their row count.
  function automatic logic [ROW_SEL_W-1:0] row_select(input int unsigned idx,
                                                      input bit active_low);
    logic [ROW_SEL_W-1:0] sel;
    sel = ROW_SEL_W'(1) << idx;
    return active_low ? ~sel : sel;
  endfunction

endpackage

// File: rtl/dot_matrix_frame_buf.sv
// Double frame buffer: pending frame written by game logic, active frame read
// by the scanner one row at a time, swapped only on the scanner's request.
module dot_matrix_frame_buf
  import dot_matrix_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 swap,
  input  logic [RW-1:0]        rd_row,
  output logic [COLS-1:0]      rd_data,
  output logic                 pending_valid
);

  logic [ROWS-1:0][COLS-1:0] pending_q;
  logic [ROWS-1:0][COLS-1:0] active_q;
  logic                      pending_valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q       <= '0;
      active_q        <= '0;
      pending_valid_q <= 1'b0;
    end else begin
      if (swap) active_q <= pending_q;
      if (load) pending_q <= frame_in;
      // A load coinciding with a swap refills pending, so it stays valid.
      if (load)      pending_valid_q <= 1'b1;
      else if (swap) pending_valid_q <= 1'b0;
    end
  end

  // On a swap edge the row being registered must come from the incoming frame.
  assign rd_data       = swap ? pending_q[rd_row] : active_q[rd_row];
  assign pending_valid = pending_valid_q;

endmodule

// File: rtl/dot_matrix_scan.sv
// Row-multiplexed scan driver for the LED dot matrix; one clk edge is one
// scan step. Rows are shown for one clock followed by a blanking gap.
module dot_matrix_scan
  import dot_matrix_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int BLINK_FRAMES   = DEF_BLINK_FRAMES,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 blink_en,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 frame_load,
  output logic                 frame_ack,
  output logic                 frame_start,
  output logic [ROWS-1:0]      row_out,
  output logic [COLS-1:0]      col_out
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [BW-1:0]   BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [FW-1:0]   FC_LAST    = FW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
  localparam logic [ROWS-1:0] ROW_IDLE   = {ROWS{ROW_ACTIVE_LOW}};
  localparam logic [COLS-1:0] COL_IDLE   = {COLS{COL_ACTIVE_LOW}};

  scan_state_t     state_q, state_d;
  logic [RW-1:0]   row_q, row_d, row_next;
  logic [BW-1:0]   blank_q, blank_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            blink_on_q, blink_on_d;
  logic            row0_entry;
  logic            swap;
  logic            pending_valid;
  logic [COLS-1:0] rd_data;
  logic [ROWS-1:0] row_out_d;
  logic [COLS-1:0] col_out_d;

  dot_matrix_frame_buf #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW)
  ) u_frame_buf (
    .clk           (clk),
    .rst           (rst),
    .load          (frame_load),
    .frame_in      (frame_in),
    .swap          (swap),
    .rd_row        (row_d),
    .rd_data       (rd_data),
    .pending_valid (pending_valid)
  );

  assign row_next = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    blank_d = blank_q;
    if (!enable) begin
      state_d = IDLE;
      row_d   = '0;
      blank_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          row_d   = '0;
          blank_d = '0;
        end
        SHOW: begin
          if (BLANK_CYCLES == 0) begin
            row_d = row_next;
          end else begin
            state_d = BLANK;
            blank_d = '0;
          end
        end
        BLANK: begin
          if (blank_q == BLANK_LAST) begin
            state_d = SHOW;
            row_d   = row_next;
            blank_d = '0;
          end else begin
            blank_d = blank_q + BW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          row_d   = '0;
          blank_d = '0;
        end
      endcase
    end
  end

  // Frame boundary: swap the buffers and advance the blink counter here only.
  always_comb begin
    row0_entry = (state_d == SHOW) && (row_d == '0);
    swap       = row0_entry && pending_valid;
    blink_on_d = blink_on_q;
    fcnt_d     = fcnt_q;
    if (!blink_en) begin
      blink_on_d = 1'b1;
      fcnt_d     = '0;
    end else if (row0_entry) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d     = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_comb begin
    row_out_d = ROW_IDLE;
    col_out_d = COL_IDLE;
    if (state_d == SHOW) begin
      row_out_d = ROWS'(row_select(32'(row_d), ROW_ACTIVE_LOW));
      if (blink_on_d) col_out_d = COL_ACTIVE_LOW ? ~rd_data : rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      blank_q     <= '0;
      fcnt_q      <= '0;
      blink_on_q  <= 1'b1;
      frame_ack   <= 1'b0;
      frame_start <= 1'b0;
      row_out     <= ROW_IDLE;
      col_out     <= COL_IDLE;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      blank_q     <= blank_d;
      fcnt_q      <= fcnt_d;
      blink_on_q  <= blink_on_d;
      frame_ack   <= swap;
      frame_start <= row0_entry;
      row_out     <= row_out_d;
      col_out     <= col_out_d;
    end
  end

endmodule
